// File: rtl/mem_resp_pipe_if.sv
// Load/store bus between the execute pipe and the data-memory responder.
// Latency: n/a (wiring only).
// Backpressure: none on the bus itself; stall is carried as a plain signal.
// Ports (master = requester side):
//   stall, rd_req, rd_addr, wr_en, wr_addr, wr_data : requester -> memory
//   rd_data, rd_valid, rd_err                       : memory -> requester
interface mem_resp_pipe_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
);
   logic              stall;
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              rd_err;

   modport master (
      output stall, rd_req, rd_addr, wr_en, wr_addr, wr_data,
      input  rd_data, rd_valid, rd_err
   );

   modport slave (
      input  stall, rd_req, rd_addr, wr_en, wr_addr, wr_data,
      output rd_data, rd_valid, rd_err
   );
endinterface

// File: rtl/mem_resp_pipe.sv
// Data-memory responder: 2^DEPTH_LOG2-word array, one read and one write port, write-first.
// Latency: load issued at edge N is presented after edge N+1 (consumed at edge N+2).
// Backpressure: stall freezes both read stages; loads offered while stalled are dropped, stores still land.
// Ports: clk, rst_n (async active-low); bus (mem_resp_pipe_if.slave) carries stall, load and store
// requests and the rd_data/rd_valid/rd_err response.
// Optional: define MEM_RESP_STATS_EN to add saturating stat_rd_cnt/stat_wr_cnt outputs.
module mem_resp_pipe #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 16,
   parameter int DEPTH_LOG2 = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mem_resp_pipe_if.slave       bus
`ifdef MEM_RESP_STATS_EN
   ,
   output logic [15:0]          stat_rd_cnt,
   output logic [15:0]          stat_wr_cnt
`endif
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [DATA_W-1:0]     mem_q [DEPTH];
   logic [DATA_W-1:0]     mem_d [DEPTH];

   logic                  s1_vld_q, s1_vld_d;
   logic                  s1_err_q, s1_err_d;
   logic [DATA_W-1:0]     s1_dat_q, s1_dat_d;
   logic                  s2_vld_q, s2_vld_d;
   logic                  s2_err_q, s2_err_d;
   logic [DATA_W-1:0]     s2_dat_q, s2_dat_d;

   logic                  rd_in_rng;
   logic                  wr_in_rng;
   logic                  wr_do;
   logic [DEPTH_LOG2-1:0] rd_idx;
   logic [DEPTH_LOG2-1:0] wr_idx;

   // Upper address bits must be zero; the array never aliases out-of-range addresses.
   assign rd_in_rng = (bus.rd_addr[ADDR_W-1:DEPTH_LOG2] == '0);
   assign wr_in_rng = (bus.wr_addr[ADDR_W-1:DEPTH_LOG2] == '0);
   assign rd_idx    = bus.rd_addr[DEPTH_LOG2-1:0];
   assign wr_idx    = bus.wr_addr[DEPTH_LOG2-1:0];
   assign wr_do     = bus.wr_en & wr_in_rng;

   // Store path: independent of stall.
   always_comb begin
      mem_d = mem_q;
      if (wr_do) begin
         mem_d[wr_idx] = bus.wr_data;
      end
   end

   // Read stages. Reading mem_d (post-write view) gives write-first ordering
   // for a same-edge store to the load address.
   always_comb begin
      s1_vld_d = s1_vld_q;
      s1_err_d = s1_err_q;
      s1_dat_d = s1_dat_q;
      s2_vld_d = s2_vld_q;
      s2_err_d = s2_err_q;
      s2_dat_d = s2_dat_q;
      if (!bus.stall) begin
         s1_vld_d = bus.rd_req;
         s1_err_d = bus.rd_req & ~rd_in_rng;
         s1_dat_d = (bus.rd_req && rd_in_rng) ? mem_d[rd_idx] : '0;
         s2_vld_d = s1_vld_q;
         s2_err_d = s1_err_q;
         s2_dat_d = s1_dat_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         s1_vld_q <= 1'b0;
         s1_err_q <= 1'b0;
         s1_dat_q <= '0;
         s2_vld_q <= 1'b0;
         s2_err_q <= 1'b0;
         s2_dat_q <= '0;
      end else begin
         mem_q    <= mem_d;
         s1_vld_q <= s1_vld_d;
         s1_err_q <= s1_err_d;
         s1_dat_q <= s1_dat_d;
         s2_vld_q <= s2_vld_d;
         s2_err_q <= s2_err_d;
         s2_dat_q <= s2_dat_d;
      end
   end

   assign bus.rd_valid = s2_vld_q;
   // err is only ever set alongside valid, so it is already 0 for bubbles.
   assign bus.rd_err   = s2_err_q;
   assign bus.rd_data  = s2_dat_q;

`ifdef MEM_RESP_STATS_EN
   logic [15:0] stat_rd_cnt_q, stat_rd_cnt_d;
   logic [15:0] stat_wr_cnt_q, stat_wr_cnt_d;

   // Saturating counters: hold at all-ones instead of wrapping.
   always_comb begin
      stat_rd_cnt_d = stat_rd_cnt_q;
      stat_wr_cnt_d = stat_wr_cnt_q;
      if (bus.rd_req && !bus.stall && (stat_rd_cnt_q != 16'hFFFF)) begin
         stat_rd_cnt_d = stat_rd_cnt_q + 16'd1;
      end
      if (wr_do && (stat_wr_cnt_q != 16'hFFFF)) begin
         stat_wr_cnt_d = stat_wr_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_rd_cnt_q <= '0;
         stat_wr_cnt_q <= '0;
      end else begin
         stat_rd_cnt_q <= stat_rd_cnt_d;
         stat_wr_cnt_q <= stat_wr_cnt_d;
      end
   end

   assign stat_rd_cnt = stat_rd_cnt_q;
   assign stat_wr_cnt = stat_wr_cnt_q;
`endif

endmodule
